// File: rtl/write_data_pkg.sv
// Shared types for the write-side controller: FSM state encoding and the
// buffered write entry layout at default widths.
package write_data_pkg;

    localparam int WR_SIZE_ADDR = 8;
    localparam int WR_SIZE_DATA = 8;
    localparam int WR_DEPTH     = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [WR_SIZE_ADDR-1:0] addr;
        logic [WR_SIZE_DATA-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/write_data_ctrl_wr_fifo.sv
// Small synchronous FIFO holding pending writes. Push is dropped when full,
// pop is dropped when empty; flags come from the registered occupancy count.
module wr_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Registers with asynchronous clear; buffered contents are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/write_data_ctrl.sv
// Write-side controller: buffers producer writes in a FIFO and issues them one
// at a time to the memory write port. A write retires on a cycle where the
// strobe o_wr_en is high and i_mem_ready is high; o_ack pulses the cycle after.
// Address/data stay stable while the strobe waits for i_mem_ready.
module write_data_ctrl
    import write_data_pkg::*;
#(
    parameter int SIZE_ADDR = WR_SIZE_ADDR,
    parameter int SIZE_DATA = WR_SIZE_DATA,
    parameter int DEPTH     = WR_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [SIZE_ADDR-1:0]       i_addr_wr,
    input  logic [SIZE_DATA-1:0]       i_data_wr,
    output logic                       o_wr_ready,
    output logic                       o_wr_en,
    output logic [SIZE_ADDR-1:0]       o_addr_wr,
    output logic [SIZE_DATA-1:0]       o_data_wr,
    input  logic                       i_mem_ready,
    output logic                       o_ack,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int EW = SIZE_ADDR + SIZE_DATA;

    wr_state_e            state_q, state_d;
    logic                 wr_en_q, wr_en_d;
    logic [SIZE_ADDR-1:0] addr_q, addr_d;
    logic [SIZE_DATA-1:0] data_q, data_d;
    logic                 ack_q, ack_d;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic [EW-1:0]        fifo_head;

    assign o_wr_ready = ~o_full;
    assign fifo_push  = i_wr_en & o_wr_ready;

    wr_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_data ({i_addr_wr, i_data_wr}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (o_count),
        .full      (o_full),
        .empty     (o_empty)
    );

    // Issue FSM: load the FIFO head into the output stage, hold it until the
    // memory accepts, then chain the next entry on the same edge if one exists.
    always_comb begin
        state_d  = state_q;
        wr_en_d  = wr_en_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ack_d    = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_en_d = 1'b0;
                if (!o_empty) begin
                    fifo_pop         = 1'b1;
                    {addr_d, data_d} = fifo_head;
                    wr_en_d          = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wr_en_d = 1'b1;
                if (i_mem_ready) begin
                    ack_d = 1'b1;
                    if (!o_empty) begin
                        fifo_pop         = 1'b1;
                        {addr_d, data_d} = fifo_head;
                    end else begin
                        wr_en_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                wr_en_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, output register stage and ack register, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_addr_wr = addr_q;
    assign o_data_wr = data_q;
    assign o_ack     = ack_q;

endmodule
